segrw_dn: RTL and testbench

Parametrised segment read/write operator for the TDF segment-ops library, the next generation of the depth-1 `segrw` FSM. It owns a DEPTH-word memory segment and consumes one {addr, dataW, write} token triple per operation: writes update the segment, reads return the stored word on dataR. Reads go through a READ_LAT-stage pipeline into a small output FIFO, so downstream backpressure does not stall accepted operations. It sits between the address/data stream producers and the dataR consumer, using the standard e/v/b stream handshake.

---
 rtl/segrw_pkg.sv | 21 ++
 rtl/segrw_dn_if.sv | 26 ++
 rtl/segrw_out_fifo.sv | 45 ++++
 rtl/segrw_dn.sv | 134 +++++++++++++
 tb/tb_segrw_dn.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/segrw_pkg.sv
// segrw_pkg: shared FSM state and statecase encodings for the segrw_dn segment operator
package segrw_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      EOS   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SC_STALL = 2'd0,
      SC_OP    = 2'd1,
      SC_EOS   = 2'd2,
      SC_PROTO = 2'd3
   } sc_t;

   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/segrw_dn_if.sv
// segrw_dn_if: addr/dataW/write token streams and the dataR stream, each with e/v/b handshake
interface segrw_dn_if #(
   parameter int DW = 16,
   parameter int AW = 8
);

   logic [AW-1:0] addr;
   logic          addr_e, addr_v, addr_b;
   logic [DW-1:0] dataW;
   logic          dataW_e, dataW_v, dataW_b;
   logic          write;
   logic          write_e, write_v, write_b;
   logic [DW-1:0] dataR;
   logic          dataR_e, dataR_v, dataR_b;

   modport master (
      output addr, addr_e, addr_v, dataW, dataW_e, dataW_v, write, write_e, write_v, dataR_b,
      input  addr_b, dataW_b, write_b, dataR, dataR_e, dataR_v
   );

   modport slave (
      input  addr, addr_e, addr_v, dataW, dataW_e, dataW_v, write, write_e, write_v, dataR_b,
      output addr_b, dataW_b, write_b, dataR, dataR_e, dataR_v
   );

endinterface

// File: rtl/segrw_out_fifo.sv
// segrw_out_fifo: DW x DEPTH first-word-fall-through FIFO with occupancy count
module segrw_out_fifo
   import segrw_pkg::*;
#(
   parameter  int DW    = 16,
   parameter  int DEPTH = 4,
   localparam int PW    = idx_w(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          nempty,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   logic          do_push, do_pop;

   assign nempty  = count != '0;
   assign do_pop  = pop && nempty;
   assign do_push = push && (32'(count) < DEPTH || do_pop);
   assign dout    = mem[rp];

   // pointer and occupancy update; simultaneous push and pop leave count unchanged
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
         if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end

   // storage needs no reset, only entries between the pointers are meaningful
   always_ff @(posedge clock)
      if (do_push) mem[wp] <= din;

endmodule

// File: rtl/segrw_dn.sv
// segrw_dn: DEPTH-word segment read/write operator with READ_LAT read pipeline and FWFT output FIFO
// SEGRW_BOUNDS_CHECK_EN: flag addr >= DEPTH on err_oob (drop writes, read 0); otherwise wrap modulo DEPTH
module segrw_dn
   import segrw_pkg::*;
#(
   parameter int DW        = 16,
   parameter int AW        = 8,
   parameter int DEPTH     = 256,
   parameter int READ_LAT  = 1,
   parameter int OUT_DEPTH = READ_LAT + 2
) (
   input  logic       clock,
   input  logic       reset,
   segrw_dn_if.slave  s,
   output logic [1:0] state,
   output logic       err_proto,
   output logic       err_oob
);

   localparam int IW = idx_w(DEPTH);
   localparam int CW = $clog2(OUT_DEPTH + 1);

   state_t        st, st_n;
   sc_t           sc;
   logic          all_v, all_e, any_e, credit, acc, rd_acc, wr_acc, wr_en;
   logic [IW-1:0] idx;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata, push_d, fifo_d;
   logic          push_v, fifo_v;
   logic [CW-1:0] cnt;
   logic [2:0]    inflight;

   assign all_v  = s.addr_v & s.dataW_v & s.write_v;
   assign all_e  = s.addr_e & s.dataW_e & s.write_e;
   assign any_e  = s.addr_e | s.dataW_e | s.write_e;
   assign credit = 32'(cnt) + 32'(inflight) < OUT_DEPTH;

   // next state and statecase; a triple is consumed in every non-stall case
   always_comb begin
      st_n = st;
      sc   = SC_STALL;
      if (st == RUN && all_v) sc = all_e ? SC_EOS : any_e ? SC_PROTO : credit ? SC_OP : SC_STALL;
      if (sc == SC_EOS) st_n = DRAIN;
      if (st == DRAIN && inflight == '0 && !fifo_v) st_n = EOS;
      if (st == EOS && !s.dataR_b) st_n = RUN;
   end

   // FSM state register
   always_ff @(posedge clock or posedge reset)
      if (reset) st <= RUN;
      else st <= st_n;

   assign acc       = sc != SC_STALL;
   assign wr_acc    = sc == SC_OP && s.write;
   assign rd_acc    = sc == SC_OP && !s.write;
   assign s.addr_b  = !acc;
   assign s.dataW_b = !acc;
   assign s.write_b = !acc;

`ifdef SEGRW_BOUNDS_CHECK_EN
   logic oob;
   assign oob   = 32'(s.addr) >= DEPTH;
   assign idx   = IW'(s.addr);
   assign wr_en = wr_acc && !oob;
   assign rdata = oob ? '0 : mem[idx];

   // sticky out-of-range flag, raised by any accepted op outside the segment
   always_ff @(posedge clock or posedge reset)
      if (reset) err_oob <= 1'b0;
      else if (sc == SC_OP && oob) err_oob <= 1'b1;
`else
   assign idx     = IW'(32'(s.addr) % 32'(DEPTH));
   assign wr_en   = wr_acc;
   assign rdata   = mem[idx];
   assign err_oob = 1'b0;
`endif

   // segment storage deliberately survives reset
   always_ff @(posedge clock)
      if (wr_en) mem[idx] <= s.dataW;

   // sticky flag for a triple whose end-of-stream bits disagree
   always_ff @(posedge clock or posedge reset)
      if (reset) err_proto <= 1'b0;
      else if (sc == SC_PROTO) err_proto <= 1'b1;

   // the FIFO write is the last read stage, so only READ_LAT-1 registers sit before it
   if (READ_LAT == 1) begin : g_lat1
      assign push_v   = rd_acc;
      assign push_d   = rdata;
      assign inflight = '0;
   end else begin : g_pipe
      logic [READ_LAT-2:0] sv;
      logic [DW-1:0]       sd [READ_LAT-1];

      // read pipeline shift; valid bits cleared on reset to discard in-flight reads
      always_ff @(posedge clock or posedge reset)
         if (reset) begin
            sv <= '0;
            for (int i = 0; i < READ_LAT - 1; i++) sd[i] <= '0;
         end else begin
            sv[0] <= rd_acc;
            sd[0] <= rdata;
            for (int i = 1; i < READ_LAT - 1; i++) begin
               sv[i] <= sv[i-1];
               sd[i] <= sd[i-1];
            end
         end

      assign push_v   = sv[READ_LAT-2];
      assign push_d   = sd[READ_LAT-2];
      assign inflight = 3'($countones(sv));
   end

   segrw_out_fifo #(
      .DW   (DW),
      .DEPTH(OUT_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_v),
      .din   (push_d),
      .pop   (!s.dataR_b),
      .dout  (fifo_d),
      .nempty(fifo_v),
      .count (cnt)
   );

   assign s.dataR   = fifo_v ? fifo_d : '0;
   assign s.dataR_v = fifo_v || st == EOS;
   assign s.dataR_e = st == EOS;
   assign state     = st;

endmodule

// File: tb/tb_segrw_dn.sv
// tb_segrw_dn: directed stimulus with a token scoreboard for segrw_dn (DEPTH=200, READ_LAT=2, OUT_DEPTH=4)
module tb_segrw_dn;

   typedef struct packed {
      logic        e;
      logic [15:0] d;
   } tok_t;

   logic clock, reset;
   logic [1:0] state;
   logic err_proto, err_oob;
   int checks = 0;
   int failures = 0;
   tok_t exp_q[$];
   tok_t t;

   segrw_dn_if #(.DW(16), .AW(8)) bus ();

   segrw_dn #(
      .DW(16), .AW(8), .DEPTH(200), .READ_LAT(2), .OUT_DEPTH(4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .s        (bus),
      .state    (state),
      .err_proto(err_proto),
      .err_oob  (err_oob)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // monitor: every delivered dataR token is matched against the scoreboard
   always @(negedge clock)
      if (!reset && bus.dataR_v && !bus.dataR_b) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_token dataR=%h e=%b required=none", bus.dataR, bus.dataR_e);
         end else begin
            t = exp_q.pop_front();
            if (bus.dataR_e !== t.e || (!t.e && bus.dataR !== t.d)) begin
               failures++;
               $display("FAIL token dataR=%h e=%b required dataR=%h e=%b", bus.dataR, bus.dataR_e, t.d, t.e);
            end
         end
      end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [15:0] d, input logic w, input logic [2:0] e);
      bus.addr = a;
      bus.dataW = d;
      bus.write = w;
      {bus.addr_e, bus.dataW_e, bus.write_e} = e;
      bus.addr_v = 1'b1;
      bus.dataW_v = 1'b1;
      bus.write_v = 1'b1;
   endtask

   task automatic idle();
      bus.addr_v = 1'b0;
      bus.dataW_v = 1'b0;
      bus.write_v = 1'b0;
      {bus.addr_e, bus.dataW_e, bus.write_e} = 3'b000;
   endtask

   task automatic send(input logic [7:0] a, input logic [15:0] d, input logic w, input logic [2:0] e);
      bit ok = 1'b0;
      drive(a, d, w, e);
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         ok = !bus.addr_b && !bus.dataW_b && !bus.write_b;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept addr=%0d actual=stalled required=accepted", a);
      end
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic rd(input logic [7:0] a, input logic [15:0] exp_d);
      send(a, 16'h0, 1'b0, 3'b000);
      exp_q.push_back({1'b0, exp_d});
   endtask

   task automatic drain_q();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
      chk("queue_empty", exp_q.size(), 0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.addr = '0;
      bus.dataW = '0;
      bus.write = 1'b0;
      bus.dataR_b = 1'b0;
      idle();
      repeat (2) @(negedge clock);
      chk("rst_addr_b", bus.addr_b, 1);
      chk("rst_dataW_b", bus.dataW_b, 1);
      chk("rst_write_b", bus.write_b, 1);
      chk("rst_dataR_v", bus.dataR_v, 0);
      chk("rst_dataR_e", bus.dataR_e, 0);
      chk("rst_dataR", bus.dataR, 0);
      chk("rst_err_proto", err_proto, 0);
      chk("rst_err_oob", err_oob, 0);
      chk("rst_state", state, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("idle_b", {bus.addr_b, bus.dataW_b, bus.write_b}, 3'b111);
      @(posedge clock);
      #1;

      // write then read with two-cycle latency, write produces no token
      send(8'd5, 16'hBEEF, 1'b1, 3'b000);
      rd(8'd5, 16'hBEEF);
      @(negedge clock);
      chk("lat_early_v", bus.dataR_v, 0);
      @(negedge clock);
      chk("lat_v", bus.dataR_v, 1);
      chk("lat_data", bus.dataR, 16'hBEEF);
      drain_q();

      // credit limit: 8 reads against a 4-entry FIFO under backpressure
      for (int k = 0; k < 8; k++) send(8'(16 + k), 16'(16'h1000 + k), 1'b1, 3'b000);
      bus.dataR_b = 1'b1;
      for (int k = 0; k < 4; k++) rd(8'(16 + k), 16'(16'h1000 + k));
      drive(8'd20, 16'h0, 1'b0, 3'b000);
      repeat (6) @(negedge clock);
      chk("credit_stall_b", {bus.addr_b, bus.dataW_b, bus.write_b}, 3'b111);
      chk("credit_head_v", bus.dataR_v, 1);
      chk("credit_head_d", bus.dataR, 16'h1000);
      @(posedge clock);
      #1 bus.dataR_b = 1'b0;
      for (int k = 4; k < 8; k++) rd(8'(16 + k), 16'(16'h1000 + k));
      drain_q();

      // end-of-stream after three reads in flight
      for (int k = 0; k < 3; k++) rd(8'(16 + k), 16'(16'h1000 + k));
      send(8'd0, 16'h0, 1'b0, 3'b111);
      exp_q.push_back({1'b1, 16'h0});
      @(negedge clock);
      chk("eos_drain_state", state, 1);
      drain_q();
      @(negedge clock);
      chk("eos_back_to_run", state, 0);
      @(posedge clock);
      #1;

      // mismatched end-of-stream bits
      send(8'd5, 16'h0, 1'b0, 3'b100);
      @(negedge clock);
      chk("proto_set", err_proto, 1);
      repeat (4) @(negedge clock);
      @(posedge clock);
      #1;
      rd(8'd5, 16'hBEEF);
      drain_q();
      chk("proto_sticky", err_proto, 1);

      // out-of-range address 210 on a 200-word segment
      send(8'd10, 16'h0A0A, 1'b1, 3'b000);
`ifdef SEGRW_BOUNDS_CHECK_EN
      rd(8'd210, 16'h0000);
      send(8'd210, 16'h5555, 1'b1, 3'b000);
      rd(8'd10, 16'h0A0A);
      drain_q();
      chk("oob_flag", err_oob, 1);
`else
      rd(8'd210, 16'h0A0A);
      send(8'd210, 16'h5555, 1'b1, 3'b000);
      rd(8'd10, 16'h5555);
      drain_q();
      chk("oob_flag", err_oob, 0);
`endif

      // reset with reads in flight discards them but keeps memory
      bus.dataR_b = 1'b1;
      send(8'd16, 16'h0, 1'b0, 3'b000);
      send(8'd17, 16'h0, 1'b0, 3'b000);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      chk("mid_rst_dataR_v", bus.dataR_v, 0);
      chk("mid_rst_b", {bus.addr_b, bus.dataW_b, bus.write_b}, 3'b111);
      chk("mid_rst_state", state, 0);
      chk("mid_rst_err_proto", err_proto, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      bus.dataR_b = 1'b0;
      repeat (3) @(negedge clock);
      chk("post_rst_dataR_v", bus.dataR_v, 0);
      @(posedge clock);
      #1;
      rd(8'd5, 16'hBEEF);
      drain_q();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
